// File: rtl/lsu_pkg.sv
// Shared constants and types for the load/store bus interface.
package lsu_pkg;

    // RV32I load/store width and sign encodings
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Width of the timeout counter; TIMEOUT_CYC must fit in it
    localparam int TO_W = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: byte enables, store replication, load extraction
// and extension, plus the misalign and illegal-encoding classification.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lanes,
    output logic [31:0] rdata_ext,
    output logic        misalign,
    output logic        illegal
);

    logic [7:0]  rbytes [4];
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign rbytes[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    assign byte_sel = rbytes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    // Decode width: lane pattern, replication, alignment and extension
    always_comb begin
        be          = 4'b0000;
        wdata_lanes = wdata;
        rdata_ext   = rdata;
        misalign    = 1'b0;
        illegal     = 1'b0;
        case (funct3)
            F3_B: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {{24{byte_sel[7]}}, byte_sel};
            end
            F3_BU: begin
                be          = 4'b0001 << addr_lo;
                wdata_lanes = {4{wdata[7:0]}};
                rdata_ext   = {24'h0, byte_sel};
            end
            F3_H: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {{16{half_sel[15]}}, half_sel};
                misalign    = addr_lo[0];
            end
            F3_HU: begin
                be          = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata_lanes = {2{wdata[15:0]}};
                rdata_ext   = {16'h0, half_sel};
                misalign    = addr_lo[0];
            end
            F3_W: begin
                be       = 4'b1111;
                misalign = |addr_lo;
            end
            default: illegal = 1'b1;
        endcase
        // Unsigned variants exist only for loads
        if (we && funct3[2]) begin
            illegal = 1'b1;
        end
    end

endmodule

// File: rtl/lsu_bus_if.sv
// Multi-cycle load/store unit: accepts one core access, runs it over a
// req/gnt/rvalid data bus with a timeout, and pulses done_o on completion.
module lsu_bus_if
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255,
    parameter int ADDR_W      = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              req_i,
    input  logic              we_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       wdata_i,
    output logic              busy_o,
    output logic              done_o,
    output logic [31:0]       rdata_o,
    output logic              misalign_o,
    output logic              err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [3:0]        mem_be_o,
    output logic [31:0]       mem_wdata_o,
    input  logic              mem_gnt_i,
    input  logic              mem_rvalid_i,
    input  logic [31:0]       mem_rdata_i
);

    lsu_state_e        state_reg, state_next;
    logic              we_reg;
    logic [2:0]        funct3_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [31:0]       wdata_reg;
    logic [TO_W-1:0]   cnt_reg;
    logic [31:0]       rdata_reg;
    logic              err_reg, err_next;
    logic              misalign_reg, misalign_next;

    logic              in_idle, in_req;
    logic              timeout;
    logic [3:0]        al_be;
    logic [31:0]       al_wdata, al_rdata;
    logic              al_misalign, al_illegal;

    assign in_idle = (state_reg == S_IDLE);
    assign in_req  = (state_reg == S_REQ);
    // Counter holds the number of cycles already spent, so the limit is hit
    // in the TIMEOUT_CYC-th busy cycle.
    assign timeout = (cnt_reg == TO_W'(TIMEOUT_CYC - 1));

    // In IDLE the incoming access is classified; afterwards the latched
    // access drives the bus lanes and load extension.
    lsu_align u_align (
        .funct3      (in_idle ? funct3_i    : funct3_reg),
        .addr_lo     (in_idle ? addr_i[1:0] : addr_reg[1:0]),
        .we          (in_idle ? we_i        : we_reg),
        .wdata       (wdata_reg),
        .rdata       (mem_rdata_i),
        .be          (al_be),
        .wdata_lanes (al_wdata),
        .rdata_ext   (al_rdata),
        .misalign    (al_misalign),
        .illegal     (al_illegal)
    );

    // Next-state and completion-flag logic
    always_comb begin
        state_next    = state_reg;
        err_next      = err_reg;
        misalign_next = misalign_reg;
        case (state_reg)
            S_IDLE: begin
                if (req_i) begin
                    err_next      = al_illegal;
                    misalign_next = !al_illegal && al_misalign;
                    state_next    = (al_illegal || al_misalign) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                // A grant wins over a simultaneous timeout: the bus has
                // already accepted the transfer.
                if (mem_gnt_i) begin
                    state_next = we_reg ? S_DONE : S_WAIT;
                end else if (timeout) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            S_WAIT: begin
                if (mem_rvalid_i) begin
                    state_next = S_DONE;
                end else if (timeout) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // State, latched access, timeout counter and result registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= S_IDLE;
            we_reg       <= 1'b0;
            funct3_reg   <= 3'b000;
            addr_reg     <= '0;
            wdata_reg    <= 32'h0;
            cnt_reg      <= '0;
            rdata_reg    <= 32'h0;
            err_reg      <= 1'b0;
            misalign_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            err_reg      <= err_next;
            misalign_reg <= misalign_next;
            if (in_idle) begin
                cnt_reg <= '0;
                if (req_i) begin
                    we_reg     <= we_i;
                    funct3_reg <= funct3_i;
                    addr_reg   <= addr_i;
                    wdata_reg  <= wdata_i;
                end
            end else if (state_reg != S_DONE) begin
                cnt_reg <= cnt_reg + TO_W'(1);
            end
            if (state_reg == S_WAIT && mem_rvalid_i) begin
                rdata_reg <= al_rdata;
            end
        end
    end

    assign busy_o      = !in_idle;
    assign done_o      = (state_reg == S_DONE);
    assign err_o       = done_o && err_reg;
    assign misalign_o  = done_o && misalign_reg;
    assign rdata_o     = rdata_reg;
    assign mem_req_o   = in_req;
    assign mem_we_o    = in_req && we_reg;
    assign mem_addr_o  = in_req ? {addr_reg[ADDR_W-1:2], 2'b00} : '0;
    assign mem_be_o    = in_req ? al_be : 4'b0000;
    assign mem_wdata_o = in_req ? al_wdata : 32'h0;

endmodule

// File: tb/tb_lsu_bus_if.sv
// Directed vector bench for lsu_bus_if with a scripted bus responder.
module tb_lsu_bus_if;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req, we;
    logic [2:0]  f3;
    logic [31:0] addr, wdata, mem_rdata;
    logic        gnt, rvalid;

    logic        busy, done, mis, err, mreq, mwe;
    logic [31:0] rdata, maddr, mwdata;
    logic [3:0]  mbe;

    // second instance with a short timeout
    logic        req_t, gnt_t, rvalid_t;
    logic        busy_t, done_t, mis_t, err_t, mreq_t, mwe_t;
    logic [31:0] rdata_t, maddr_t, mwdata_t;
    logic [3:0]  mbe_t;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    lsu_bus_if dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .busy_o(busy), .done_o(done),
        .rdata_o(rdata), .misalign_o(mis), .err_o(err), .mem_req_o(mreq),
        .mem_we_o(mwe), .mem_addr_o(maddr), .mem_be_o(mbe), .mem_wdata_o(mwdata),
        .mem_gnt_i(gnt), .mem_rvalid_i(rvalid), .mem_rdata_i(mem_rdata)
    );

    lsu_bus_if #(.TIMEOUT_CYC(4)) dut_to (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_t), .we_i(we), .funct3_i(f3),
        .addr_i(addr), .wdata_i(wdata), .busy_o(busy_t), .done_o(done_t),
        .rdata_o(rdata_t), .misalign_o(mis_t), .err_o(err_t), .mem_req_o(mreq_t),
        .mem_we_o(mwe_t), .mem_addr_o(maddr_t), .mem_be_o(mbe_t), .mem_wdata_o(mwdata_t),
        .mem_gnt_i(gnt_t), .mem_rvalid_i(rvalid_t), .mem_rdata_i(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          gnt_dly;
        int          rv_dly;
        logic        early_rv;
        logic [31:0] exp_maddr;
        logic [3:0]  exp_be;
        logic [31:0] exp_mwdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        logic        exp_err;
        int          exp_lat;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [2:0] f, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] rd,
                                input int gd, input int rv, input logic erv,
                                input logic [31:0] ema, input logic [3:0] eb,
                                input logic [31:0] ewd, input logic [31:0] erd,
                                input logic em, input logic ee, input int lat);
        vec_t v;
        v.we = w; v.f3 = f; v.addr = a; v.wdata = wd; v.rdata = rd;
        v.gnt_dly = gd; v.rv_dly = rv; v.early_rv = erv;
        v.exp_maddr = ema; v.exp_be = eb; v.exp_mwdata = ewd; v.exp_rdata = erd;
        v.exp_mis = em; v.exp_err = ee; v.exp_lat = lat;
        return v;
    endfunction

    // Issue one access on dut and play the bus side with the given delays
    task automatic run_vec(input vec_t v, input int idx);
        int req_cyc;
        int g_cyc;
        int done_cyc;
        req_cyc  = 0;
        g_cyc    = -1;
        done_cyc = -1;
        @(negedge clk);
        req = 1'b1; we = v.we; f3 = v.f3; addr = v.addr; wdata = v.wdata;
        gnt = 1'b0; rvalid = 1'b0; mem_rdata = 32'h0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            gnt = 1'b0;
            rvalid = 1'b0;
            if (done) begin
                done_cyc = c;
                break;
            end
            if (mreq) begin
                req_cyc++;
                chk($sformatf("v%0d mem_we", idx), {31'h0, mwe}, {31'h0, v.we});
                chk($sformatf("v%0d mem_addr", idx), maddr, v.exp_maddr);
                chk($sformatf("v%0d mem_be", idx), {28'h0, mbe}, {28'h0, v.exp_be});
                if (v.we) chk($sformatf("v%0d mem_wdata", idx), mwdata, v.exp_mwdata);
                if (req_cyc == v.gnt_dly + 1) begin
                    gnt = 1'b1;
                    g_cyc = c;
                    if (v.early_rv) begin
                        rvalid = 1'b1;
                        mem_rdata = 32'h5555_5555;
                    end
                end
            end
            if (!v.we && g_cyc > 0 && c == g_cyc + v.rv_dly) begin
                rvalid = 1'b1;
                mem_rdata = v.rdata;
            end
        end
        req = 1'b0;
        chk($sformatf("v%0d latency", idx), done_cyc, v.exp_lat);
        chk($sformatf("v%0d misalign", idx), {31'h0, mis}, {31'h0, v.exp_mis});
        chk($sformatf("v%0d err", idx), {31'h0, err}, {31'h0, v.exp_err});
        chk($sformatf("v%0d rdata", idx), rdata, v.exp_rdata);
        chk($sformatf("v%0d mem_req_in_done", idx), {31'h0, mreq}, 32'h0);
        chk($sformatf("v%0d req_cycles", idx), req_cyc,
            (v.exp_mis || v.exp_err) ? 0 : v.gnt_dly + 1);
        @(negedge clk);
        chk($sformatf("v%0d done_one_cycle", idx), {31'h0, done}, 32'h0);
        chk($sformatf("v%0d busy_after", idx), {31'h0, busy}, 32'h0);
        chk($sformatf("v%0d rdata_held", idx), rdata, v.exp_rdata);
        $display("[TB] vec %0d we=%0d f3=%b addr=%h lat=%0d rdata=%h mis=%0d err=%0d",
                 idx, v.we, v.f3, v.addr, done_cyc, rdata, mis, err);
    endtask

    // Load on the short-timeout instance where the bus never completes
    task automatic run_timeout(input logic give_gnt);
        int req_cyc;
        int done_cyc;
        req_cyc  = 0;
        done_cyc = -1;
        @(negedge clk);
        req_t = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h700;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            gnt_t = 1'b0;
            if (done_t) begin
                done_cyc = c;
                chk("to err", {31'h0, err_t}, 32'h1);
                chk("to mem_req_in_done", {31'h0, mreq_t}, 32'h0);
                chk("to rdata", rdata_t, 32'h0);
                break;
            end
            if (mreq_t) begin
                req_cyc++;
                if (give_gnt) gnt_t = 1'b1;
            end
        end
        req_t = 1'b0;
        chk("to latency", done_cyc, 5);
        chk("to req_cycles", req_cyc, give_gnt ? 1 : 4);
        $display("[TB] timeout gnt=%0d lat=%0d req_cycles=%0d", give_gnt, done_cyc, req_cyc);
    endtask

    initial begin
        vec_t v_after;
        rst_n = 1'b0;
        req = 1'b0; we = 1'b0; f3 = 3'b000; addr = 32'h0; wdata = 32'h0;
        mem_rdata = 32'h0; gnt = 1'b0; rvalid = 1'b0;
        req_t = 1'b0; gnt_t = 1'b0; rvalid_t = 1'b0;

        //          we  f3     addr   wdata         rdata         gd rv erv  maddr  be       mwdata        exp_rdata     mis err lat
        vecs[0]  = mk(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        0, 0, 0, 32'h100, 4'b1111, 32'hDEADBEEF, 32'h00000000, 0, 0, 2);
        vecs[1]  = mk(1, 3'b000, 32'h203, 32'h000000A5, 32'h0,        0, 0, 0, 32'h200, 4'b1000, 32'hA5A5A5A5, 32'h00000000, 0, 0, 2);
        vecs[2]  = mk(0, 3'b000, 32'h203, 32'h0,        32'h80FF7F00, 0, 1, 0, 32'h200, 4'b1000, 32'h0,        32'hFFFFFF80, 0, 0, 3);
        vecs[3]  = mk(0, 3'b100, 32'h203, 32'h0,        32'h80FF7F00, 0, 1, 0, 32'h200, 4'b1000, 32'h0,        32'h00000080, 0, 0, 3);
        vecs[4]  = mk(0, 3'b001, 32'h302, 32'h0,        32'h80011234, 2, 2, 0, 32'h300, 4'b1100, 32'h0,        32'hFFFF8001, 0, 0, 6);
        vecs[5]  = mk(0, 3'b101, 32'h302, 32'h0,        32'h80011234, 2, 2, 0, 32'h300, 4'b1100, 32'h0,        32'h00008001, 0, 0, 6);
        vecs[6]  = mk(0, 3'b010, 32'h401, 32'h0,        32'h0,        0, 1, 0, 32'h400, 4'b1111, 32'h0,        32'h00008001, 1, 0, 1);
        vecs[7]  = mk(0, 3'b011, 32'h500, 32'h0,        32'h0,        0, 1, 0, 32'h500, 4'b0000, 32'h0,        32'h00008001, 0, 1, 1);
        vecs[8]  = mk(1, 3'b001, 32'h402, 32'h1234ABCD, 32'h0,        0, 0, 0, 32'h400, 4'b1100, 32'hABCDABCD, 32'h00008001, 0, 0, 2);
        vecs[9]  = mk(0, 3'b001, 32'h000, 32'h0,        32'h12347FFF, 0, 1, 0, 32'h000, 4'b0011, 32'h0,        32'h00007FFF, 0, 0, 3);
        vecs[10] = mk(1, 3'b100, 32'h000, 32'h11111111, 32'h0,        0, 0, 0, 32'h000, 4'b0001, 32'h0,        32'h00007FFF, 0, 1, 1);
        vecs[11] = mk(0, 3'b000, 32'h001, 32'h0,        32'h00008000, 0, 1, 0, 32'h000, 4'b0010, 32'h0,        32'hFFFFFF80, 0, 0, 3);
        vecs[12] = mk(0, 3'b001, 32'h001, 32'h0,        32'h0,        0, 1, 0, 32'h000, 4'b0011, 32'h0,        32'hFFFFFF80, 1, 0, 1);
        vecs[13] = mk(0, 3'b010, 32'h600, 32'h0,        32'hCAFEF00D, 1, 3, 1, 32'h600, 4'b1111, 32'h0,        32'hCAFEF00D, 0, 0, 6);
        vecs[14] = mk(1, 3'b000, 32'h001, 32'h00000077, 32'h0,        3, 0, 0, 32'h000, 4'b0010, 32'h77777777, 32'hCAFEF00D, 0, 0, 5);

        // reset state
        #3;
        chk("reset busy", {31'h0, busy}, 32'h0);
        chk("reset done", {31'h0, done}, 32'h0);
        chk("reset mem_req", {31'h0, mreq}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            run_vec(vecs[i], i);
        end

        run_timeout(1'b0);
        run_timeout(1'b1);

        // reset while a load waits for rvalid
        @(negedge clk);
        req = 1'b1; we = 1'b0; f3 = 3'b010; addr = 32'h800;
        @(negedge clk);
        chk("rst seq mem_req", {31'h0, mreq}, 32'h1);
        gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
        chk("rst seq in wait", {31'h0, busy & ~mreq}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst async busy", {31'h0, busy}, 32'h0);
        chk("rst async mem_req", {31'h0, mreq}, 32'h0);
        chk("rst async rdata", rdata, 32'h0);
        chk("rst async be", {28'h0, mbe}, 32'h0);
        req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        rvalid = 1'b1; mem_rdata = 32'h12345678;
        @(negedge clk);
        rvalid = 1'b0;
        chk("late rvalid done", {31'h0, done}, 32'h0);
        chk("late rvalid busy", {31'h0, busy}, 32'h0);
        chk("late rvalid rdata", rdata, 32'h0);
        $display("[TB] reset in WAIT: busy=%0d rdata=%h", busy, rdata);

        v_after = mk(0, 3'b100, 32'h802, 32'h0, 32'h00AB0000, 0, 1, 0,
                     32'h800, 4'b0100, 32'h0, 32'h000000AB, 0, 0, 3);
        run_vec(v_after, 15);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
